axis_seq_checker: RTL and testbench

//   AXI-Stream receiver (slave) endpoint for 32-bit streams. Accepts beats under a

---
 rtl/axis_chk_pkg.sv | 18 +
 rtl/axis_seq_checker_if.sv | 25 ++
 rtl/axis_lfsr_throttle.sv | 25 ++
 rtl/axis_seq_checker.sv | 136 +++++++++++++
 tb/tb_axis_seq_checker.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_chk_pkg.sv
// Shared types and constants for the AXI-Stream sequence checker.
// State encoding, LFSR constants and default widths.
package axis_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 32;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/axis_seq_checker_if.sv
// AXI-Stream handshake bundle used between a source and the checker.
// master drives data/valid, slave drives ready.
interface axis_seq_checker_if
  import axis_chk_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/axis_lfsr_throttle.sv
// Pseudo-random ready gating: a free-running 16-bit LFSR compared
// against a level; a higher level means fewer ready cycles.
module axis_lfsr_throttle
  import axis_chk_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] lvl,
  output logic       gate_ok
);

  logic [15:0] lfsr;

  // advance the LFSR once per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & LFSR_TAPS);
    end
  end

  assign gate_ok = (lfsr[3:0] >= lvl);

endmodule

// File: rtl/axis_seq_checker.sv
// AXI-Stream sink that checks beats against an incrementing sequence.
// Optional ready throttling: define AXIS_RX_THROTTLE_EN.
module axis_seq_checker
  import axis_chk_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter bit STOP_ON_ERR = 1'b0
)(
  input  logic              clk,
  input  logic              rst,
  axis_seq_checker_if.slave s,
  input  logic              enable,
  input  logic              clear,
  input  logic [DATA_W-1:0] seed,
`ifdef AXIS_RX_THROTTLE_EN
  input  logic [3:0]        throttle_lvl,
`endif
  output logic [CNT_W-1:0]  beat_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              mismatch,
  output logic              first_err_valid,
  output logic [DATA_W-1:0] first_err_data,
  output logic [DATA_W-1:0] first_err_exp
);

  state_t            state;
  state_t            state_nx;
  logic [DATA_W-1:0] exp_val;
  logic              ready_q;
  logic              gate_ok;
  logic              take;
  logic              bad;
  logic              load;

`ifdef AXIS_RX_THROTTLE_EN
  axis_lfsr_throttle u_thr (
    .clk     (clk),
    .rst     (rst),
    .lvl     (throttle_lvl),
    .gate_ok (gate_ok)
  );
`else
  assign gate_ok = 1'b1;
`endif

  assign s.tready = ready_q;
  // a beat arriving together with clear completes on the bus but is dropped
  assign take = s.tvalid && ready_q && !clear;
  assign bad  = (s.tdata != exp_val);
  assign load = (state == IDLE) && (state_nx == RUN);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (enable && !clear) state_nx = RUN;
      end
      RUN: begin
        if (clear || !enable) begin
          state_nx = IDLE;
        end else if (STOP_ON_ERR && take && bad) begin
          state_nx = HALT;
        end
      end
      HALT: begin
        if (clear) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ready: only while staying in RUN, so it rises a cycle after entry
  // and falls on the same edge that leaves RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= (state == RUN) && (state_nx == RUN) && gate_ok;
    end
  end

  // expected value: seed on start, +1 on match, resync after a mismatch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_val <= '0;
    end else if (load) begin
      exp_val <= seed;
    end else if (take) begin
      exp_val <= bad ? s.tdata + 1'b1 : exp_val + 1'b1;
    end
  end

  // counters, mismatch pulse and first-error capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_count      <= '0;
      err_count       <= '0;
      mismatch        <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_data  <= '0;
      first_err_exp   <= '0;
    end else begin
      mismatch <= 1'b0;
      if (clear) begin
        beat_count      <= '0;
        err_count       <= '0;
        first_err_valid <= 1'b0;
        first_err_data  <= '0;
        first_err_exp   <= '0;
      end else if (take) begin
        if (beat_count != '1) beat_count <= beat_count + 1'b1;
        if (bad) begin
          mismatch <= 1'b1;
          if (err_count != '1) err_count <= err_count + 1'b1;
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_data  <= s.tdata;
            first_err_exp   <= exp_val;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_seq_checker.sv
// Directed bench for axis_seq_checker: default, halt-on-error and
// narrow-counter instances side by side.
module tb_axis_seq_checker;
  import axis_chk_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] td[3];
  logic [31:0] sd[3];
  logic [2:0]  tv;
  logic [2:0]  en;
  logic [2:0]  cl;
  wire  [2:0]  rdy;
  logic [3:0]  lvl;

  logic [31:0] bc[2];
  logic [31:0] ec[2];
  logic [31:0] fd[3];
  logic [31:0] fe[3];
  logic [3:0]  bc2;
  logic [3:0]  ec2;
  logic [2:0]  mm;
  logic [2:0]  fv;

  int checks = 0;
  int failures = 0;

  axis_seq_checker_if #(.DATA_W(32)) ifa ();
  axis_seq_checker_if #(.DATA_W(32)) ifb ();
  axis_seq_checker_if #(.DATA_W(32)) ifc ();

  assign ifa.tdata  = td[0];
  assign ifa.tvalid = tv[0];
  assign rdy[0]     = ifa.tready;
  assign ifb.tdata  = td[1];
  assign ifb.tvalid = tv[1];
  assign rdy[1]     = ifb.tready;
  assign ifc.tdata  = td[2];
  assign ifc.tvalid = tv[2];
  assign rdy[2]     = ifc.tready;

  axis_seq_checker u_dut0 (
    .clk             (clk),
    .rst             (rst),
    .s               (ifa),
    .enable          (en[0]),
    .clear           (cl[0]),
    .seed            (sd[0]),
`ifdef AXIS_RX_THROTTLE_EN
    .throttle_lvl    (lvl),
`endif
    .beat_count      (bc[0]),
    .err_count       (ec[0]),
    .mismatch        (mm[0]),
    .first_err_valid (fv[0]),
    .first_err_data  (fd[0]),
    .first_err_exp   (fe[0])
  );

  axis_seq_checker #(.STOP_ON_ERR(1'b1)) u_dut1 (
    .clk             (clk),
    .rst             (rst),
    .s               (ifb),
    .enable          (en[1]),
    .clear           (cl[1]),
    .seed            (sd[1]),
`ifdef AXIS_RX_THROTTLE_EN
    .throttle_lvl    (4'd0),
`endif
    .beat_count      (bc[1]),
    .err_count       (ec[1]),
    .mismatch        (mm[1]),
    .first_err_valid (fv[1]),
    .first_err_data  (fd[1]),
    .first_err_exp   (fe[1])
  );

  axis_seq_checker #(.CNT_W(4)) u_dut2 (
    .clk             (clk),
    .rst             (rst),
    .s               (ifc),
    .enable          (en[2]),
    .clear           (cl[2]),
    .seed            (sd[2]),
`ifdef AXIS_RX_THROTTLE_EN
    .throttle_lvl    (4'd0),
`endif
    .beat_count      (bc2),
    .err_count       (ec2),
    .mismatch        (mm[2]),
    .first_err_valid (fv[2]),
    .first_err_data  (fd[2]),
    .first_err_exp   (fe[2])
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] beats;
    logic [31:0] errs;
    logic        pulse;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear(int k);
    cl[k] = 1'b1;
    tick(1);
    cl[k] = 1'b0;
  endtask

  // present one beat and hold it until the handshake edge
  task automatic send(int k, logic [31:0] d, output int stalls);
    stalls = 0;
    td[k] = d;
    tv[k] = 1'b1;
    @(negedge clk);
    while (!rdy[k] && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    if (!rdy[k]) begin
      checks++;
      failures++;
      $display("FAIL send_timeout dut%0d: got ready=0 want ready=1", k);
    end
    @(posedge clk);
    #1;
    tv[k] = 1'b0;
  endtask

  int st;
  int sum;
  int hs;
  logic r;

  initial begin
    for (int k = 0; k < 3; k++) begin
      td[k] = '0;
      sd[k] = '0;
    end
    tv = '0;
    en = '0;
    cl = '0;
    lvl = 4'd0;

    tbl[0] = '{32'd0,  32'd1, 32'd0, 1'b0};
    tbl[1] = '{32'd1,  32'd2, 32'd0, 1'b0};
    tbl[2] = '{32'd2,  32'd3, 32'd0, 1'b0};
    tbl[3] = '{32'd3,  32'd4, 32'd0, 1'b0};
    tbl[4] = '{32'd4,  32'd5, 32'd0, 1'b0};
    tbl[5] = '{32'd9,  32'd6, 32'd1, 1'b1};
    tbl[6] = '{32'd10, 32'd7, 32'd1, 1'b0};

    tick(3);
    chk("rst_beats", bc[0], 0);
    chk("rst_errs", ec[0], 0);
    chk("rst_ready", {31'd0, rdy[0]}, 0);
    chk("rst_mismatch", {31'd0, mm[0]}, 0);
    chk("rst_fev", {31'd0, fv[0]}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(1);

    // back-to-back run from 0x100
    sd[0] = 32'h100;
    en[0] = 1'b1;
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      send(0, 32'h100 + i, st);
      if (i > 0) sum += st;
    end
    chk("t1_stalls", sum, 0);
    chk("t1_beats", bc[0], 16);
    chk("t1_errs", ec[0], 0);

    // one discontinuity from seed 0
    sd[0] = 32'd0;
    pulse_clear(0);
    chk("clr_beats", bc[0], 0);
    for (int i = 0; i < 7; i++) begin
      send(0, tbl[i].data, st);
      chk($sformatf("t2_beats_%0d", i), bc[0], tbl[i].beats);
      chk($sformatf("t2_errs_%0d", i), ec[0], tbl[i].errs);
      chk($sformatf("t2_pulse_%0d", i), {31'd0, mm[0]}, {31'd0, tbl[i].pulse});
    end
    chk("t2_fev", {31'd0, fv[0]}, 1);
    chk("t2_fed", fd[0], 9);
    chk("t2_fee", fe[0], 5);

    // expected value wraps without an error
    sd[0] = 32'hFFFF_FFFF;
    pulse_clear(0);
    send(0, 32'hFFFF_FFFF, st);
    send(0, 32'h0, st);
    send(0, 32'h1, st);
    chk("wrap_beats", bc[0], 3);
    chk("wrap_errs", ec[0], 0);

    // beat on the edge where enable falls is still counted
    td[0] = 32'h2;
    tv[0] = 1'b1;
    en[0] = 1'b0;
    tick(1);
    tv[0] = 1'b0;
    chk("enfall_beats", bc[0], 4);
    chk("enfall_ready", {31'd0, rdy[0]}, 0);

    // clear wins over a simultaneous (bad) transfer
    en[0] = 1'b1;
    tick(3);
    chk("clrx_ready", {31'd0, rdy[0]}, 1);
    td[0] = 32'h55;
    tv[0] = 1'b1;
    cl[0] = 1'b1;
    tick(1);
    tv[0] = 1'b0;
    cl[0] = 1'b0;
    chk("clrx_beats", bc[0], 0);
    chk("clrx_errs", ec[0], 0);
    chk("clrx_fev", {31'd0, fv[0]}, 0);
    chk("clrx_pulse", {31'd0, mm[0]}, 0);

`ifdef AXIS_RX_THROTTLE_EN
    sd[0] = 32'd0;
    pulse_clear(0);
    tick(3);
    lvl = 4'd8;
    td[0] = 32'd0;
    tv[0] = 1'b1;
    hs = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      r = rdy[0];
      @(posedge clk);
      #1;
      if (r) begin
        hs++;
        td[0] = td[0] + 1;
      end
    end
    tv[0] = 1'b0;
    lvl = 4'd0;
    chk("thr_beats", bc[0], hs);
    chk("thr_errs", ec[0], 0);
    chk("thr_duty", {31'd0, (hs >= 400 && hs <= 600)}, 1);
`endif

    // halt on first mismatch
    sd[1] = 32'd0;
    en[1] = 1'b1;
    send(1, 32'd0, st);
    send(1, 32'd1, st);
    send(1, 32'd7, st);
    chk("halt_ready", {31'd0, rdy[1]}, 0);
    chk("halt_beats", bc[1], 3);
    chk("halt_errs", ec[1], 1);
    chk("halt_pulse", {31'd0, mm[1]}, 1);
    chk("halt_fed", fd[1], 7);
    chk("halt_fee", fe[1], 2);
    en[1] = 1'b0;
    tick(2);
    en[1] = 1'b1;
    tick(3);
    chk("halt_en_toggle", {31'd0, rdy[1]}, 0);
    sd[1] = 32'h50;
    pulse_clear(1);
    send(1, 32'h50, st);
    chk("halt_resume_beats", bc[1], 1);
    chk("halt_resume_errs", ec[1], 0);
    chk("halt_resume_fev", {31'd0, fv[1]}, 0);

    // narrow counters saturate
    sd[2] = 32'd0;
    en[2] = 1'b1;
    for (int i = 0; i < 20; i++) send(2, i, st);
    chk("sat_beats", {28'd0, bc2}, 15);
    chk("sat_errs", {28'd0, ec2}, 0);

    // asynchronous reset in the middle of a burst
    sd[0] = 32'h10;
    pulse_clear(0);
    send(0, 32'h10, st);
    send(0, 32'h11, st);
    chk("pre_rst_beats", bc[0], 2);
    td[0] = 32'h12;
    tv[0] = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", {31'd0, rdy[0]}, 0);
    chk("arst_beats", bc[0], 0);
    chk("arst_errs", ec[0], 0);
    chk("arst_sat_beats", {28'd0, bc2}, 0);
    en[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick(5);
    chk("post_rst_idle_beats", bc[0], 0);
    chk("post_rst_idle_ready", {31'd0, rdy[0]}, 0);
    tv[0] = 1'b0;
    en[0] = 1'b1;
    send(0, 32'h10, st);
    chk("post_rst_beats", bc[0], 1);
    chk("post_rst_errs", ec[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
